// File: rtl/divider_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encoding,
// step-counter width and constant helpers used to build all-ones / most-negative values.
package divider_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } div_state_t;

  localparam int unsigned MAX_W = 64;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  function automatic logic [MAX_W-1:0] all_ones(input int unsigned w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [MAX_W-1:0] most_neg(input int unsigned w);
    logic [MAX_W-1:0] v;
    v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/divider_iterative_step.sv
// One combinational radix-2 restoring step: shift in a dividend bit, trial-subtract |D|.
module divider_step
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH_D = 16
) (
  input  logic [WIDTH_D:0]   rem_in,
  input  logic               n_bit,
  input  logic [WIDTH_D-1:0] d_mag,
  output logic [WIDTH_D:0]   rem_out,
  output logic               q_bit
);

  logic [WIDTH_D+1:0] partial;
  logic [WIDTH_D+1:0] diff;

  // One spare bit above the partial remainder makes the borrow a clean sign bit.
  always_comb begin
    partial = {rem_in, n_bit};
    diff    = partial - {2'b00, d_mag};
    q_bit   = ~diff[WIDTH_D+1];
    rem_out = q_bit ? diff[WIDTH_D:0] : partial[WIDTH_D:0];
  end

endmodule

// File: rtl/divider_iterative.sv
// Sequential radix-2 restoring divider, one quotient bit per cycle, valid/ready both sides.
// Optional div_by_zero output port enabled by defining DIV_ERR_FLAG_EN.
module divider_iterative
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH_N = 16,
  parameter int unsigned WIDTH_D = 16,
  parameter bit          SIGNED  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] N,
  input  logic [WIDTH_D-1:0] D,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] Q,
  output logic [WIDTH_D-1:0] R
`ifdef DIV_ERR_FLAG_EN
  ,
  output logic               div_by_zero
`endif
);

  localparam int unsigned          CNT_W      = cnt_width(WIDTH_N);
  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(WIDTH_N - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
  localparam logic [MAX_W-1:0]     ONES_N_F   = all_ones(WIDTH_N);
  localparam logic [MAX_W-1:0]     ONES_D_F   = all_ones(WIDTH_D);
  localparam logic [MAX_W-1:0]     MNEG_N_F   = most_neg(WIDTH_N);
  localparam logic [WIDTH_N-1:0]   ONES_N     = ONES_N_F[WIDTH_N-1:0];
  localparam logic [WIDTH_D-1:0]   ONES_D     = ONES_D_F[WIDTH_D-1:0];
  localparam logic [WIDTH_N-1:0]   MOST_NEG_N = MNEG_N_F[WIDTH_N-1:0];

  div_state_t state_q, state_d;

  logic [WIDTH_N-1:0] n_cap;
  logic [WIDTH_D-1:0] d_cap;
  logic [WIDTH_N-1:0] quo;
  logic [WIDTH_D:0]   rem;
  logic [WIDTH_D:0]   rem_next;
  logic [WIDTH_D-1:0] d_mag;
  logic [CNT_W-1:0]   cnt;
  logic               sign_q, sign_r;
  logic [WIDTH_N-1:0] q_out;
  logic [WIDTH_D-1:0] r_out;
  logic               q_bit;
  logic               d_zero, ovf, n_neg, d_neg;

  assign d_zero = (d_cap == '0);
  assign n_neg  = SIGNED & n_cap[WIDTH_N-1];
  assign d_neg  = SIGNED & d_cap[WIDTH_D-1];
  assign ovf    = SIGNED & (n_cap == MOST_NEG_N) & (d_cap == ONES_D);

  divider_step #(.WIDTH_D(WIDTH_D)) u_step (
    .rem_in  (rem),
    .n_bit   (quo[WIDTH_N-1]),
    .d_mag   (d_mag),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Special results bypass CALC but still take one FIX cycle (with no sign
  // fix-up), giving them a fixed two-cycle latency.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_PREP;
      ST_PREP: state_d = (d_zero || ovf) ? ST_FIX : ST_CALC;
      ST_CALC: if (cnt == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_cap  <= '0;
      d_cap  <= '0;
      quo    <= '0;
      rem    <= '0;
      d_mag  <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      q_out  <= '0;
      r_out  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            n_cap <= N;
            d_cap <= D;
          end
        end
        ST_PREP: begin
          cnt <= CNT_LAST;
          rem <= '0;
          if (d_zero) begin
            quo    <= ONES_N;
            rem    <= {1'b0, n_cap[WIDTH_D-1:0]};
            sign_q <= 1'b0;
            sign_r <= 1'b0;
          end else if (ovf) begin
            quo    <= n_cap;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
          end else begin
            quo    <= n_neg ? -n_cap : n_cap;
            d_mag  <= d_neg ? -d_cap : d_cap;
            sign_q <= n_neg ^ d_neg;
            sign_r <= n_neg;
          end
        end
        ST_CALC: begin
          quo <= {quo[WIDTH_N-2:0], q_bit};
          rem <= rem_next;
          cnt <= cnt - CNT_ONE;
        end
        ST_FIX: begin
          q_out <= sign_q ? -quo : quo;
          r_out <= sign_r ? -rem[WIDTH_D-1:0] : rem[WIDTH_D-1:0];
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign Q         = q_out;
  assign R         = r_out;

`ifdef DIV_ERR_FLAG_EN
  assign div_by_zero = (state_q == ST_DONE) & d_zero;
`endif

endmodule

// File: tb/tb_divider_iterative.sv
// Scoreboard bench for divider_iterative: unsigned and signed instances, directed vectors.
module tb_divider_iterative;

  logic clk = 1'b0;
  logic rst;

  logic        iv_u, ir_u, ov_u, or_u;
  logic [15:0] n_u, d_u, q_u, r_u;
  logic        iv_s, ir_s, ov_s, or_s;
  logic [15:0] n_s, d_s, q_s, r_s;
`ifdef DIV_ERR_FLAG_EN
  logic        dbz_u, dbz_s;
`endif

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } exp_t;

  exp_t exp_u[$];
  exp_t exp_s[$];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  divider_iterative #(.WIDTH_N(16), .WIDTH_D(16), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(iv_u), .in_ready(ir_u), .N(n_u), .D(d_u),
    .out_valid(ov_u), .out_ready(or_u), .Q(q_u), .R(r_u)
`ifdef DIV_ERR_FLAG_EN
    , .div_by_zero(dbz_u)
`endif
  );

  divider_iterative #(.WIDTH_N(16), .WIDTH_D(16), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir_s), .N(n_s), .D(d_s),
    .out_valid(ov_s), .out_ready(or_s), .Q(q_s), .R(r_s)
`ifdef DIV_ERR_FLAG_EN
    , .div_by_zero(dbz_s)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ov_u && or_u) begin
        if (exp_u.size() == 0) check("unexpected_out_u", 32'(q_u), 32'hDEAD_BEEF);
        else begin
          e = exp_u.pop_front();
          check("q_u", 32'(q_u), 32'(e.q));
          check("r_u", 32'(r_u), 32'(e.r));
`ifdef DIV_ERR_FLAG_EN
          check("dbz_u", 32'(dbz_u), 32'(e.dbz));
`endif
        end
      end
      if (!rst && ov_s && or_s) begin
        if (exp_s.size() == 0) check("unexpected_out_s", 32'(q_s), 32'hDEAD_BEEF);
        else begin
          e = exp_s.pop_front();
          check("q_s", 32'(q_s), 32'(e.q));
          check("r_s", 32'(r_s), 32'(e.r));
`ifdef DIV_ERR_FLAG_EN
          check("dbz_s", 32'(dbz_s), 32'(e.dbz));
`endif
        end
      end
    end
  end

  task automatic run_op(input bit sgn, input logic [15:0] n, input logic [15:0] d,
                        input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                        input int lat, input string name);
    int cyc;
    exp_t e;
    e.q = eq; e.r = er; e.dbz = edbz;
    cyc = 0;
    while (!(sgn ? ir_s : ir_u) && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    if (cyc >= 50) check({name, "_ready_timeout"}, 32'(cyc), 32'd0);
    if (sgn) begin
      n_s = n; d_s = d; iv_s = 1'b1; exp_s.push_back(e);
    end else begin
      n_u = n; d_u = d; iv_u = 1'b1; exp_u.push_back(e);
    end
    @(posedge clk); #1;
    iv_s = 1'b0; iv_u = 1'b0;
    cyc = 0;
    while (!(sgn ? ov_s : ov_u) && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'(lat));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] q0, r0;
    int seen;
    rst = 1'b1;
    iv_u = 1'b0; iv_s = 1'b0; or_u = 1'b1; or_s = 1'b1;
    n_u = '0; d_u = '0; n_s = '0; d_s = '0;
    #1;
    check("rst_in_ready_u", 32'(ir_u), 32'd1);
    check("rst_out_valid_u", 32'(ov_u), 32'd0);
    check("rst_q_u", 32'(q_u), 32'd0);
    check("rst_r_u", 32'(r_u), 32'd0);
    check("rst_in_ready_s", 32'(ir_s), 32'd1);
    check("rst_out_valid_s", 32'(ov_s), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 18, "u_100_7");
    run_op(1'b1, 16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 18, "s_m100_7");
    run_op(1'b1, 16'd100,  16'hFFF9, 16'hFFF2, 16'd2,    1'b0, 18, "s_100_m7");
    run_op(1'b1, 16'hFFF9, 16'hFFFE, 16'd3,    16'hFFFF, 1'b0, 18, "s_m7_m2");
    run_op(1'b0, 16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1, 2,  "u_div0");
    run_op(1'b1, 16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1, 2,  "s_div0");
    run_op(1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0, 2,  "s_ovf");
    run_op(1'b0, 16'h8000, 16'hFFFF, 16'd0,    16'h8000, 1'b0, 18, "u_8000_ffff");
    run_op(1'b1, 16'h8000, 16'd2,    16'hC000, 16'd0,    1'b0, 18, "s_mneg_2");
    run_op(1'b0, 16'hFFFF, 16'd1,    16'hFFFF, 16'd0,    1'b0, 18, "u_ffff_1");
    run_op(1'b0, 16'd5,    16'd10,   16'd0,    16'd5,    1'b0, 18, "u_5_10");

    // Backpressure: result held in DONE, competing request must not be taken.
    or_u = 1'b0;
    run_op(1'b0, 16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 18, "u_bp");
    q0 = q_u; r0 = r_u;
    n_u = 16'd7; d_u = 16'd1; iv_u = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_q_stable", 32'(q_u), 32'(q0));
      check("bp_r_stable", 32'(r_u), 32'(r0));
      check("bp_in_ready", 32'(ir_u), 32'd0);
      check("bp_out_valid", 32'(ov_u), 32'd1);
    end
    iv_u = 1'b0;
    or_u = 1'b1;
    @(posedge clk); #1;
    check("bp_back_idle", 32'(ir_u), 32'd1);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (ov_u) seen++;
    end
    check("bp_second_not_taken", 32'(seen), 32'd0);

    // Reset mid-CALC aborts the operation without producing a result.
    n_u = 16'd1000; d_u = 16'd3; iv_u = 1'b1;
    @(posedge clk); #1;
    iv_u = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("midcalc_busy", 32'(ir_u), 32'd0);
    rst = 1'b1;
    #1;
    check("midcalc_rst_out_valid", 32'(ov_u), 32'd0);
    check("midcalc_rst_in_ready", 32'(ir_u), 32'd1);
    check("midcalc_rst_q", 32'(q_u), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 16'd45, 16'd9, 16'd5, 16'd0, 1'b0, 18, "u_45_9");

    repeat (3) @(posedge clk);
    #1;
    check("queue_u_drained", 32'(exp_u.size()), 32'd0);
    check("queue_s_drained", 32'(exp_s.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
